// File: rtl/button_arb_pkg.sv
// Shared types and constants for the button event arbiter and its per-channel filters.
package button_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_e;

    localparam int unsigned DEFAULT_SAMPLE_DIV = 100000;
    localparam int unsigned DEFAULT_STABLE_CNT = 3;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, tick-sampled history window and
// filtered pressed state with a one-cycle rise strobe.
module btn_channel
    import button_arb_pkg::*;
#(
    parameter int unsigned STABLE_CNT = DEFAULT_STABLE_CNT
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic rise,
    output logic stab
);

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic [STABLE_CNT-2:0] hist_q, hist_d;
    logic                  stab_q, stab_d;
    logic [STABLE_CNT-1:0] window;

    // The window is the stored history plus the sample taken on this tick.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        window  = {hist_q, sync2_q};
        hist_d  = hist_q;
        stab_d  = stab_q;
        rise    = 1'b0;
        if (tick) begin
            hist_d = window[STABLE_CNT-2:0];
            if (&window) begin
                stab_d = 1'b1;
            end else if (~|window) begin
                stab_d = 1'b0;
            end
            rise = ~stab_q & (&window);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= '0;
            stab_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            stab_q  <= stab_d;
        end
    end

    assign stab = stab_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced button front end: per-channel filters feed a pending register that a
// round-robin arbiter drains one symbol at a time over valid/ready.
module button_event_arbiter
    import button_arb_pkg::*;
#(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
    parameter int unsigned STABLE_CNT = DEFAULT_STABLE_CNT,
    localparam int unsigned ID_W      = clog2(N_BTN),
    localparam int unsigned CNT_W     = clog2(SAMPLE_DIV)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             sym_ready,
    output logic             sym_valid,
    output logic [ID_W-1:0]  sym_id,
    output logic [N_BTN-1:0] pending,
    output logic             overflow
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic [N_BTN-1:0] rise, stab;
    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] clr;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic             hi_found;
    logic [ID_W-1:0]  hi_idx, lo_idx, pick_idx;

    always_comb begin
        tick  = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .STABLE_CNT(STABLE_CNT)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .btn_raw(btn_in[i]),
            .rise   (rise[i]),
            .stab   (stab[i])
        );

        rise_sets_stab: assert property (@(posedge clk) disable iff (reset) rise[i] |=> stab[i]);
    end

    // Lowest set bit at or above rr_q wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                lo_idx = ID_W'(i);
                if (i >= int'(rr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        pick_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rr_d    = rr_q;
        accept  = 1'b0;
        clr     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    id_d    = pick_idx;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (sym_ready) begin
                    accept  = 1'b1;
                    state_d = ST_IDLE;
                    rr_d    = (32'(id_q) == N_BTN - 1) ? '0 : id_q + ID_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        for (int i = 0; i < N_BTN; i++) begin
            clr[i] = accept && (int'(id_q) == i);
        end
        // A rise on the bit being cleared wins so the new press is reported again.
        pend_d = (pend_q & ~clr) | rise;
        ovf_d  = ovf_q | (|(rise & pend_q & ~clr));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            id_q    <= '0;
            rr_q    <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sym_valid = (state_q == ST_OFFER);
    assign sym_id    = id_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with a run-length behavioural model
// compared every cycle, plus hand-computed checkpoints.
module tb_button_event_arbiter;

    localparam int SD = 4;
    localparam int SC = 3;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_in;
    logic          sym_ready;
    logic          sym_valid;
    logic [1:0]    sym_id;
    logic [NB-1:0] pending;
    logic          overflow;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int hs_q[$];
    int hs_t[$];

    button_event_arbiter #(
        .N_BTN     (NB),
        .SAMPLE_DIV(SD),
        .STABLE_CNT(SC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .sym_ready(sym_ready),
        .sym_valid(sym_valid),
        .sym_id   (sym_id),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: each channel tracks the value and length of its current run of samples.
    logic [NB-1:0] m_s1, m_s2, m_stab, m_pend, m_run_val;
    int            m_run_len[NB];
    int            m_n, m_id, m_rr;
    logic          m_valid, m_ovf;
    logic          m_init = 1'b0;

    always @(posedge clk) begin
        logic          tick;
        logic [NB-1:0] rise, clr, p_old;
        int            j;
        cyc++;
        if (reset) begin
            m_init = 1'b1;
            m_s1 = '0; m_s2 = '0; m_stab = '0; m_pend = '0; m_run_val = '0;
            for (int i = 0; i < NB; i++) m_run_len[i] = SC;
            m_n = 0; m_id = 0; m_rr = 0; m_valid = 1'b0; m_ovf = 1'b0;
        end else begin
            tick = ((m_n % SD) == SD - 1);
            rise = '0;
            if (tick) begin
                for (int i = 0; i < NB; i++) begin
                    if (m_s2[i] == m_run_val[i]) begin
                        if (m_run_len[i] < SC) m_run_len[i]++;
                    end else begin
                        m_run_val[i] = m_s2[i];
                        m_run_len[i] = 1;
                    end
                    if (m_run_len[i] >= SC) begin
                        if (m_run_val[i] && !m_stab[i]) rise[i] = 1'b1;
                        m_stab[i] = m_run_val[i];
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
            clr = '0;
            p_old = m_pend;
            if (m_valid && sym_ready) begin
                clr[m_id] = 1'b1;
                m_rr = (m_id + 1) % NB;
                m_valid = 1'b0;
            end else if (!m_valid && p_old != '0) begin
                for (int k = NB - 1; k >= 0; k--) begin
                    j = (m_rr + k) % NB;
                    if (p_old[j]) m_id = j;
                end
                m_valid = 1'b1;
            end
            if ((rise & p_old & ~clr) != '0) m_ovf = 1'b1;
            m_pend = (p_old & ~clr) | rise;
            m_n++;
        end
        if (!reset && sym_valid && sym_ready) begin
            hs_q.push_back(int'(sym_id));
            hs_t.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_valid", 32'(sym_valid), 32'(m_valid));
            if (m_valid) chk("model_id", 32'(sym_id), 32'(m_id));
            chk("model_pending", 32'(pending), 32'(m_pend));
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        hs_q.delete();
        hs_t.delete();
    endtask

    task automatic wait_hs(input int n, input int budget, input string name);
        int c = 0;
        while (hs_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, 32'(hs_q.size()), 32'(n));
    endtask

    initial begin
        int lat;
        int vcnt;
        int c;
        reset = 1'b1;
        btn_in = 4'b1111;
        sym_ready = 1'b0;

        // 1: reset holds everything low, then all four rise on the third tick.
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", 32'(sym_valid), 0);
            chk("rst_id", 32'(sym_id), 0);
            chk("rst_pending", 32'(pending), 0);
            chk("rst_overflow", 32'(overflow), 0);
        end
        reset = 1'b0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            chk("post_rst_pend_low", 32'(pending), 0);
        end
        @(negedge clk);
        chk("post_rst_third_tick", 32'(pending), 32'h0000_000f);

        // 2: clean press on ch2 with ready high.
        btn_in = '0;
        do_reset(2);
        sym_ready = 1'b1;
        repeat (5) @(negedge clk);
        btn_in[2] = 1'b1;
        lat = 0;
        while (!pending[2] && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("press_latency_in_range", 32'(lat >= 10 && lat <= 14), 1);
        @(negedge clk);
        chk("press_valid_next", 32'(sym_valid), 1);
        chk("press_id", 32'(sym_id), 2);
        vcnt = 1;
        repeat (35) begin
            @(negedge clk);
            if (sym_valid) vcnt++;
        end
        chk("press_one_pulse", 32'(vcnt), 1);
        chk("press_one_hs", 32'(hs_q.size()), 1);
        chk("press_hs_id", 32'(hs_q[0]), 2);
        chk("press_pend_clear", 32'(pending), 0);
        btn_in = '0;
        repeat (25) @(negedge clk);

        // 3: bounce on ch0 shorter than the filter window.
        hs_q.delete();
        for (int k = 0; k < 6; k++) begin
            btn_in[0] = (k % 2 == 0);
            repeat (5) @(negedge clk);
        end
        btn_in[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("bounce_no_hs", 32'(hs_q.size()), 0);
        chk("bounce_pending", 32'(pending), 0);
        chk("bounce_overflow", 32'(overflow), 0);

        // 4: simultaneous presses served round-robin from rr_ptr=0.
        btn_in = '0;
        do_reset(2);
        sym_ready = 1'b1;
        btn_in = 4'b1011;
        wait_hs(3, 40, "simul_hs_count");
        chk("simul_first", 32'(hs_q[0]), 0);
        chk("simul_second", 32'(hs_q[1]), 1);
        chk("simul_third", 32'(hs_q[2]), 3);
        btn_in = '0;
        repeat (25) @(negedge clk);
        hs_q.delete();
        hs_t.delete();
        btn_in = 4'b0011;
        wait_hs(2, 40, "simul2_hs_count");
        chk("simul2_first", 32'(hs_q[0]), 0);
        chk("simul2_second", 32'(hs_q[1]), 1);
        btn_in = '0;
        repeat (25) @(negedge clk);

        // 5: backpressure holds the ch1 offer while ch3 arrives.
        sym_ready = 1'b0;
        hs_q.delete();
        hs_t.delete();
        btn_in[1] = 1'b1;
        c = 0;
        while (!sym_valid && c < 30) begin
            @(negedge clk);
            c++;
        end
        chk("bp_offer", 32'(sym_valid), 1);
        for (int k = 0; k < 30; k++) begin
            if (k == 10) btn_in[3] = 1'b1;
            @(negedge clk);
            chk("bp_hold_valid", 32'(sym_valid), 1);
            chk("bp_hold_id", 32'(sym_id), 1);
        end
        chk("bp_pending", 32'(pending), 32'h0000_000a);
        sym_ready = 1'b1;
        wait_hs(2, 20, "bp_hs_count");
        chk("bp_first", 32'(hs_q[0]), 1);
        chk("bp_second", 32'(hs_q[1]), 3);
        chk("bp_spacing", 32'(hs_t[1] - hs_t[0]), 2);
        btn_in = '0;
        sym_ready = 1'b0;
        repeat (25) @(negedge clk);

        // 6: second press of ch2 while still pending sets the sticky overflow.
        hs_q.delete();
        btn_in[2] = 1'b1;
        c = 0;
        while (!pending[2] && c < 30) begin
            @(negedge clk);
            c++;
        end
        chk("ovf_first_pend", 32'(pending), 32'h0000_0004);
        repeat (4) @(negedge clk);
        btn_in[2] = 1'b0;
        repeat (20) @(negedge clk);
        chk("ovf_not_yet", 32'(overflow), 0);
        btn_in[2] = 1'b1;
        repeat (20) @(negedge clk);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_pend_merged", 32'(pending), 32'h0000_0004);
        sym_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("ovf_one_hs", 32'(hs_q.size()), 1);
        chk("ovf_hs_id", 32'(hs_q[0]), 2);
        chk("ovf_pend_clear", 32'(pending), 0);
        repeat (20) @(negedge clk);
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_still_one_hs", 32'(hs_q.size()), 1);
        btn_in = '0;
        reset = 1'b1;
        @(negedge clk);
        chk("ovf_reset_clears", 32'(overflow), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
